dram_mmio_ctrl: RTL and testbench

- Parametrised data memory with a memory-mapped I/O window, driven directly by the single-cycle CPU data port: ADDR from DataD, DATA from DataB, MW, and Q to Din.
- Generalises the fixed 3-in/4-out DRAM I/O scheme to configurable width and depth, and configurable input and output port counts.
- Adds input synchronisers, sticky change flags with write-1-to-clear, and a prescaled free-running timer.
- Reads are combinational, so the single-cycle datapath is kept; all state updates on the rising CLK edge.

---
 rtl/dram_mmio_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dram_mmio_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_mmio_ctrl.sv
// dram_mmio_ctrl: word-addressed data RAM with a memory-mapped I/O window on top.
// The window holds synchronised input ports, registered output ports, sticky change
// flags (write-1-to-clear) and a prescaled free-running timer. Reads are
// combinational so a single-cycle CPU can use Q directly. All state changes on the
// rising CLK edge.
module dram_mmio_ctrl #(
  parameter int             DW       = 8,
  parameter int             AW       = 8,
  parameter int             NUM_IN   = 3,
  parameter int             NUM_OUT  = 4,
  parameter logic [AW-1:0]  IO_BASE  = 8'hF0,
  parameter int             PRESCALE = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [AW-1:0]           ADDR,
  input  logic [DW-1:0]           DATA,
  input  logic                    MW,
  output logic [DW-1:0]           Q,
  input  logic [NUM_IN*DW-1:0]    IO_IN,
  output logic [NUM_OUT*DW-1:0]   IO_OUT,
  output logic                    CHG_ANY
);

  localparam int RAM_DEPTH = int'(IO_BASE);
  localparam int OFF_OUT   = NUM_IN;
  localparam int OFF_CHG   = NUM_IN + NUM_OUT;
  localparam int OFF_TMR   = NUM_IN + NUM_OUT + 1;
  localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  // Each input port needs its own change-flag bit inside one data word.
  if (NUM_IN < 1 || NUM_IN > DW) begin : g_bad_num_in
    $error("dram_mmio_ctrl: NUM_IN must be in 1..DW");
  end

  logic [DW-1:0]     ram_r   [RAM_DEPTH];
  logic [DW-1:0]     sync1_r [NUM_IN];
  logic [DW-1:0]     sync2_r [NUM_IN];
  logic [DW-1:0]     prev_r  [NUM_IN];
  logic [DW-1:0]     out_r   [NUM_OUT];
  logic [NUM_IN-1:0] chg_r;
  logic              chg_any_r;
  logic [DW-1:0]     timer_r;
  logic [PW-1:0]     presc_r;

  logic              io_sel_s;
  logic [AW-1:0]     off_s;
  int                off_ext_s;
  logic              wr_io_s;
  logic              wr_chg_s;
  logic              wr_tmr_s;
  logic [NUM_OUT-1:0] wr_out_s;
  logic [DW-1:0]     rd_in_s;
  logic [DW-1:0]     rd_out_s;
  logic [DW-1:0]     chg_word_s;
  logic [DW-1:0]     q_s;

  // Offset arithmetic wraps in AW bits; only meaningful when io_sel_s is set.
  assign io_sel_s  = (ADDR >= IO_BASE);
  assign off_s     = ADDR - IO_BASE;
  assign off_ext_s = int'(off_s);
  assign wr_io_s   = MW & io_sel_s;
  assign wr_chg_s  = wr_io_s & (off_ext_s == OFF_CHG);
  assign wr_tmr_s  = wr_io_s & (off_ext_s == OFF_TMR);

  // Per-output-port write strobes.
  always_comb begin
    wr_out_s = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      wr_out_s[j] = wr_io_s & (off_ext_s == OFF_OUT + j);
    end
  end

  // Read mux: RAM below IO_BASE, register file above; unmapped offsets read zero.
  always_comb begin
    q_s        = '0;
    rd_in_s    = '0;
    rd_out_s   = '0;
    chg_word_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rd_in_s = rd_in_s | ((off_ext_s == i) ? sync2_r[i] : '0);
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      rd_out_s = rd_out_s | ((off_ext_s == OFF_OUT + j) ? out_r[j] : '0);
    end
    chg_word_s[NUM_IN-1:0] = chg_r;
    if (!io_sel_s) begin
      q_s = ram_r[ADDR];
    end else if (off_ext_s < OFF_OUT) begin
      q_s = rd_in_s;
    end else if (off_ext_s < OFF_CHG) begin
      q_s = rd_out_s;
    end else if (off_ext_s == OFF_CHG) begin
      q_s = chg_word_s;
    end else if (off_ext_s == OFF_TMR) begin
      q_s = timer_r;
    end else begin
      q_s = '0;
    end
  end

  // RAM storage: untouched by RESET, but a write during RESET is discarded.
  always_ff @(posedge CLK) begin
    if (MW && !RESET && !io_sel_s) begin
      ram_r[ADDR] <= DATA;
    end
  end

  // Input synchronisers, sticky change flags (set beats clear) and CHG_ANY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_r[i] <= '0;
        sync2_r[i] <= '0;
        prev_r[i]  <= '0;
      end
      chg_r     <= '0;
      chg_any_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_r[i] <= IO_IN[i*DW +: DW];
        sync2_r[i] <= sync1_r[i];
        prev_r[i]  <= sync2_r[i];
        chg_r[i]   <= (sync2_r[i] != prev_r[i]) | (chg_r[i] & ~(wr_chg_s & DATA[i]));
      end
      chg_any_r <= |chg_r;
    end
  end

  // Output port registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        out_r[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (wr_out_s[j]) begin
          out_r[j] <= DATA;
        end
      end
    end
  end

  // Prescaled timer; a CPU write loads the value and restarts the prescaler.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_r <= '0;
      presc_r <= '0;
    end else if (wr_tmr_s) begin
      timer_r <= DATA;
      presc_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      timer_r <= timer_r + DW'(1);
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_io_out
    assign IO_OUT[j*DW +: DW] = out_r[j];
  end

  assign Q       = q_s;
  assign CHG_ANY = chg_any_r;

endmodule

// File: tb/tb_dram_mmio_ctrl.sv
// Bench for dram_mmio_ctrl: directed literal checks followed by random traffic,
// all outputs compared every cycle against a behavioural model of the block.
module tb_dram_mmio_ctrl;

  localparam int NI = 3;
  localparam int NO = 4;
  localparam int P  = 4;

  logic        CLK;
  logic        RESET;
  logic [7:0]  ADDR;
  logic [7:0]  DATA;
  logic        MW;
  logic [7:0]  Q;
  logic [23:0] IO_IN;
  logic [31:0] IO_OUT;
  logic        CHG_ANY;

  dram_mmio_ctrl #(
    .DW(8), .AW(8), .NUM_IN(NI), .NUM_OUT(NO), .IO_BASE(8'hF0), .PRESCALE(P)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DATA(DATA), .MW(MW), .Q(Q),
    .IO_IN(IO_IN), .IO_OUT(IO_OUT), .CHG_ANY(CHG_ANY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [7:0]  ram_m [256];
  bit          ram_known [256];
  logic [7:0]  smp [3][NI];   // [0] newest sample, [1] visible value, [2] one before
  bit [NI-1:0] flags_m;
  bit          chg_any_m;
  logic [7:0]  out_m [NO];
  logic [7:0]  tbase;
  int          tcyc;
  bit          model_ok = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timer = last loaded value plus one tick per P cycles since the load, mod 256.
  function automatic logic [7:0] timer_m();
    return 8'(tbase + 8'(tcyc / P));
  endfunction

  function automatic bit exp_q(input logic [7:0] a, output logic [7:0] v);
    int off;
    off = int'(a) - 240;
    v = 8'h00;
    if (a < 8'hF0) begin
      v = ram_m[a];
      return ram_known[a];
    end
    if (off < NI)              v = smp[1][off];
    else if (off < NI + NO)    v = out_m[off - NI];
    else if (off == NI + NO)   v = 8'(flags_m);
    else if (off == NI + NO + 1) v = timer_m();
    else                       v = 8'h00;
    return 1'b1;
  endfunction

  // Model update on each rising edge using the inputs held during the cycle.
  always @(posedge CLK) begin : model
    int off;
    off = int'(ADDR) - 240;
    if (RESET) begin
      for (int s = 0; s < 3; s++)
        for (int i = 0; i < NI; i++) smp[s][i] = 8'h00;
      flags_m   = '0;
      chg_any_m = 1'b0;
      for (int j = 0; j < NO; j++) out_m[j] = 8'h00;
      tbase    = 8'h00;
      tcyc     = 0;
      model_ok = 1'b1;
    end else begin
      chg_any_m = |flags_m;
      for (int i = 0; i < NI; i++)
        flags_m[i] = (smp[1][i] != smp[2][i]) ||
                     (flags_m[i] && !(MW && off == NI + NO && DATA[i]));
      smp[2] = smp[1];
      smp[1] = smp[0];
      for (int i = 0; i < NI; i++) smp[0][i] = IO_IN[i*8 +: 8];
      tcyc++;
      if (MW) begin
        if (ADDR < 8'hF0) begin
          ram_m[ADDR]     = DATA;
          ram_known[ADDR] = 1'b1;
        end else if (off >= NI && off < NI + NO) begin
          out_m[off - NI] = DATA;
        end else if (off == NI + NO + 1) begin
          tbase = DATA;
          tcyc  = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin : cmp
    logic [7:0] v;
    bit known;
    if (model_ok) begin
      known = exp_q(ADDR, v);
      if (known) check("q_model", {24'h0, Q}, {24'h0, v});
      check("io_out_model", IO_OUT, {out_m[3], out_m[2], out_m[1], out_m[0]});
      check("chg_any_model", {31'h0, CHG_ANY}, {31'h0, chg_any_m});
    end
  end

  task automatic cyc(input logic r, input logic m, input logic [7:0] a, input logic [7:0] d);
    RESET = r; MW = m; ADDR = a; DATA = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic peek(input logic [7:0] a);
    RESET = 1'b0; MW = 1'b0; ADDR = a; DATA = 8'h00;
    #1;
  endtask

  initial begin
    RESET = 1'b1; MW = 1'b0; ADDR = 8'h00; DATA = 8'h00; IO_IN = 24'h0;
    @(posedge CLK);
    #1;
    // Reset state and RAM round trip.
    peek(8'hF8);  check("timer_after_reset", {24'h0, Q}, 32'h0);
    check("io_out_reset", IO_OUT, 32'h0);
    check("chg_any_reset", {31'h0, CHG_ANY}, 32'h0);
    cyc(1'b0, 1'b1, 8'h10, 8'hA5);
    peek(8'h10);  check("ram_roundtrip", {24'h0, Q}, 32'hA5);

    // Output port write, and a write to a read-only input port.
    cyc(1'b0, 1'b1, 8'hF4, 8'h3C);
    check("io_out1_write", IO_OUT, 32'h0000_3C00);
    peek(8'hF4);  check("out1_readback", {24'h0, Q}, 32'h3C);
    cyc(1'b0, 1'b1, 8'hF0, 8'hFF);
    check("in_write_ignored_out", IO_OUT, 32'h0000_3C00);
    peek(8'hF0);  check("in_write_ignored_in", {24'h0, Q}, 32'h0);

    // Input synchroniser latency and change flag on port 2.
    IO_IN = 24'h55_0000;
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    peek(8'hF2);  check("sync_1edge", {24'h0, Q}, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    peek(8'hF2);  check("sync_2edge", {24'h0, Q}, 32'h55);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    peek(8'hF7);  check("chg_set", {24'h0, Q}, 32'h04);
    check("chg_any_lag", {31'h0, CHG_ANY}, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    check("chg_any_set", {31'h0, CHG_ANY}, 32'h1);
    cyc(1'b0, 1'b1, 8'hF7, 8'h04);
    peek(8'hF7);  check("chg_cleared", {24'h0, Q}, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    check("chg_any_cleared", {31'h0, CHG_ANY}, 32'h0);

    // Set and W1C of flag 0 on the same edge: set wins.
    IO_IN = 24'h55_0001;
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 8'hF7, 8'h01);
    peek(8'hF7);  check("set_beats_clear", {24'h0, Q}, 32'h01);
    cyc(1'b0, 1'b1, 8'hF7, 8'h01);
    peek(8'hF7);  check("clear_after_collision", {24'h0, Q}, 32'h0);

    // Reset together with writes discards them, RAM included.
    cyc(1'b0, 1'b1, 8'h20, 8'h5A);
    cyc(1'b0, 1'b1, 8'hF3, 8'h99);
    check("out0_write", IO_OUT, 32'h0000_3C99);
    cyc(1'b1, 1'b1, 8'hF3, 8'h77);
    cyc(1'b1, 1'b1, 8'h20, 8'h11);
    check("reset_drops_out_write", IO_OUT, 32'h0);
    peek(8'h20);  check("reset_drops_ram_write", {24'h0, Q}, 32'h5A);

    // Timer with prescale 4: 40 cycles -> 10, then wrap from FE.
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    peek(8'hF8);  check("timer_40cyc", {24'h0, Q}, 32'h0A);
    cyc(1'b0, 1'b1, 8'hF8, 8'hFE);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    peek(8'hF8);  check("timer_ff", {24'h0, Q}, 32'hFF);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    peek(8'hF8);  check("timer_wrap", {24'h0, Q}, 32'h00);

    // Random traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      RESET = ($urandom_range(0, 99) == 0);
      MW    = ($urandom_range(0, 9) < 4);
      ADDR  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255))
                                          : 8'($urandom_range(0, 63));
      DATA  = 8'($urandom);
      for (int k = 0; k < NI; k++)
        if ($urandom_range(0, 7) == 0) IO_IN[k*8 +: 8] = 8'($urandom);
      @(posedge CLK);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
